// File: rtl/mopshub_seq_pkg.sv
// MOPSHUB bus test sequencer shared types.
// State encoding, phase bit indices and phase ordering helper.
package mopshub_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT_SO,
    S_TRIM,
    S_RX,
    S_ENDWAIT,
    S_GAP,
    S_TX,
    S_CUSTOM,
    S_NEXT_BUS,
    S_DONE
  } seq_state_t;

  localparam int MODE_TRIM   = 0;
  localparam int MODE_RX     = 1;
  localparam int MODE_TX     = 2;
  localparam int MODE_CUSTOM = 3;

  // First enabled phase at or after index 'from'; NEXT_BUS when none left.
  function automatic seq_state_t first_phase(
    input logic [3:0] m,
    input int         from
  );
    seq_state_t s;
    s = S_NEXT_BUS;
    if (from <= MODE_CUSTOM && m[MODE_CUSTOM]) s = S_CUSTOM;
    if (from <= MODE_TX && m[MODE_TX])         s = S_TX;
    if (from <= MODE_RX && m[MODE_RX])         s = S_RX;
    if (from <= MODE_TRIM && m[MODE_TRIM])     s = S_TRIM;
    return s;
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter shared by phase timeout, endwait and gap.
// Expire is masked in the load cycle so a stale count never fires.
module seq_timer #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_expire
);

  logic [W-1:0] r_cnt;

  // Reload on request, otherwise count down and park at zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expire = !i_load && (r_cnt == W'(1));

endmodule

// File: rtl/mopshub_bus_test_sequencer.sv
// MOPSHUB bring-up sequencer walking N CAN buses through
// trim, RX, endwait/gap, TX and custom phases with timeouts.
module mopshub_bus_test_sequencer
  import mopshub_seq_pkg::*;
#(
  parameter int N_BUSES     = 32,
  parameter int GAP_CYC     = 120,
  parameter int ENDWAIT_LEN = 1,
  parameter int TO_CYC      = 65535,
  localparam int BUS_W = (N_BUSES > 1) ? $clog2(N_BUSES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [3:0]       mode_mask,
  input  logic [BUS_W:0]   n_buses,
  input  logic             sign_on,
  input  logic             trim_done,
  input  logic             rx_end,
  input  logic             tx_end,
  input  logic             custom_end,
  output logic             osc_auto_trim,
  output logic             test_rx,
  output logic             test_tx,
  output logic             test_advanced,
  output logic             endwait_all,
  output logic [BUS_W-1:0] bus_sel,
  output logic             busy,
  output logic             done,
  output logic             err_timeout,
  output logic [BUS_W:0]   fail_cnt
);

  localparam int TO_W = $clog2(TO_CYC + 1);
  localparam int G_W  = $clog2(GAP_CYC + 1);
  localparam int E_W  = $clog2(ENDWAIT_LEN + 1);
  localparam int CW0  = (TO_W > G_W) ? TO_W : G_W;
  localparam int CW   = (CW0 > E_W) ? CW0 : E_W;

  // Counts are "cycles after the load cycle"; single-cycle
  // states exit on their first cycle instead of using the timer.
  localparam int TO_LD  = TO_CYC - 1;
  localparam int EW_LD  = ENDWAIT_LEN - 1;
  localparam int GAP_LD = (GAP_CYC > 2) ? GAP_CYC - 2 : 0;
  localparam bit EW_ONE  = (ENDWAIT_LEN == 1);
  localparam bit GAP_ONE = (GAP_CYC == 2);
  localparam logic [BUS_W:0] N_MAX = (BUS_W + 1)'(N_BUSES);

  seq_state_t       r_state;
  logic [3:0]       r_mask;
  logic [BUS_W:0]   r_n;
  logic [BUS_W-1:0] r_bus;
  logic [3:0]       r_lvl;
  logic             r_endwait;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [BUS_W:0]   r_fail;
  logic             r_ld;

  logic             w_end;
  logic [1:0]       w_idx;
  logic [CW-1:0]    w_val;
  logic             w_exp;

  seq_timer #(.W(CW)) u_timer (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_load   (r_ld),
    .i_value  (w_val),
    .o_expire (w_exp)
  );

  // Select the end pulse, level index and timer reload for the state.
  always_comb begin
    w_end = 1'b0;
    w_idx = 2'd0;
    w_val = CW'(TO_LD);
    case (r_state)
      S_TRIM:    begin w_end = trim_done;  w_idx = 2'(MODE_TRIM);   end
      S_RX:      begin w_end = rx_end;     w_idx = 2'(MODE_RX);     end
      S_TX:      begin w_end = tx_end;     w_idx = 2'(MODE_TX);     end
      S_CUSTOM:  begin w_end = custom_end; w_idx = 2'(MODE_CUSTOM); end
      S_ENDWAIT: w_val = CW'(EW_LD);
      S_GAP:     w_val = CW'(GAP_LD);
      default:   ;
    endcase
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_mask    <= '0;
      r_n       <= '0;
      r_bus     <= '0;
      r_lvl     <= '0;
      r_endwait <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_fail    <= '0;
      r_ld      <= 1'b0;
    end else begin
      r_ld   <= 1'b0;
      r_done <= 1'b0;
      if (abort && r_state != S_IDLE) begin
        r_state   <= S_IDLE;
        r_lvl     <= '0;
        r_endwait <= 1'b0;
        r_busy    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_err  <= 1'b0;
              r_fail <= '0;
              r_bus  <= '0;
              r_busy <= 1'b1;
              if (n_buses == '0 || mode_mask == 4'd0) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_mask  <= mode_mask;
                r_n     <= (n_buses > N_MAX) ? N_MAX : n_buses;
                r_state <= S_WAIT_SO;
                r_ld    <= 1'b1;
              end
            end
          end
          S_WAIT_SO: begin
            if (sign_on) begin
              r_state <= first_phase(r_mask, 0);
              r_ld    <= 1'b1;
            end else if (w_exp) begin
              r_err   <= 1'b1;
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
          S_TRIM, S_RX, S_TX, S_CUSTOM: begin
            if (w_end) begin
              r_lvl <= '0;
              r_ld  <= 1'b1;
              if (r_state == S_RX) begin
                r_state   <= S_ENDWAIT;
                r_endwait <= 1'b1;
              end else begin
                r_state <= first_phase(r_mask, int'(w_idx) + 1);
              end
            end else if (w_exp) begin
              r_lvl   <= '0;
              r_err   <= 1'b1;
              r_state <= S_NEXT_BUS;
              if (r_fail != '1) r_fail <= r_fail + 1'b1;
            end else begin
              r_lvl[w_idx] <= 1'b1;
            end
          end
          S_ENDWAIT: begin
            if (EW_ONE || w_exp) begin
              r_endwait <= 1'b0;
              r_ld      <= 1'b1;
              r_state   <= (GAP_CYC > 1) ? S_GAP
                         : first_phase(r_mask, MODE_TX);
            end
          end
          S_GAP: begin
            if (GAP_ONE || w_exp) begin
              r_ld    <= 1'b1;
              r_state <= first_phase(r_mask, MODE_TX);
            end
          end
          S_NEXT_BUS: begin
            if ({1'b0, r_bus} == r_n - 1'b1) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_bus   <= r_bus + 1'b1;
              r_ld    <= 1'b1;
              r_state <= first_phase(r_mask, 0);
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign osc_auto_trim = r_lvl[MODE_TRIM];
  assign test_rx       = r_lvl[MODE_RX];
  assign test_tx       = r_lvl[MODE_TX];
  assign test_advanced = r_lvl[MODE_CUSTOM];
  assign endwait_all   = r_endwait;
  assign bus_sel       = r_bus;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err_timeout   = r_err;
  assign fail_cnt      = r_fail;

endmodule

// File: tb/tb_mopshub_bus_test_sequencer.sv
// Self-checking bench for mopshub_bus_test_sequencer.
// A reactive driver answers phases from a plan; expectations come from the rules.
module tb_mopshub_bus_test_sequencer;

  localparam int NB  = 4;
  localparam int GAP = 6;
  localparam int EWL = 1;
  localparam int TO  = 50;
  localparam int BW  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [3:0] mode_mask = 4'd0;
  logic [BW:0] n_buses = '0;
  logic sign_on = 1'b1;
  logic trim_done = 1'b0;
  logic rx_end = 1'b0;
  logic tx_end = 1'b0;
  logic custom_end = 1'b0;
  logic osc_auto_trim, test_rx, test_tx, test_advanced;
  logic endwait_all, busy, done, err_timeout;
  logic [BW-1:0] bus_sel;
  logic [BW:0] fail_cnt;

  int checks = 0;
  int errors = 0;
  int plan_q[$];
  int obs_q[$];
  int hi_q[$];
  int ew_q[$];
  int gap_q[$];
  bit stray_en = 1'b0;

  mopshub_bus_test_sequencer #(
    .N_BUSES(NB), .GAP_CYC(GAP), .ENDWAIT_LEN(EWL), .TO_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .mode_mask(mode_mask), .n_buses(n_buses), .sign_on(sign_on),
    .trim_done(trim_done), .rx_end(rx_end), .tx_end(tx_end),
    .custom_end(custom_end), .osc_auto_trim(osc_auto_trim),
    .test_rx(test_rx), .test_tx(test_tx),
    .test_advanced(test_advanced), .endwait_all(endwait_all),
    .bus_sel(bus_sel), .busy(busy), .done(done),
    .err_timeout(err_timeout), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] lvl();
    return {test_advanced, test_tx, test_rx, osc_auto_trim};
  endfunction

  task automatic clr_ends();
    trim_done = 0; rx_end = 0; tx_end = 0; custom_end = 0;
  endtask

  task automatic pulse_end(input int p);
    case (p)
      0: trim_done = 1;
      1: rx_end = 1;
      2: tx_end = 1;
      default: custom_end = 1;
    endcase
  endtask

  function automatic bit q_eq(input int a[$], input int b[$]);
    if (a.size() != b.size()) return 0;
    foreach (a[i]) if (a[i] != b[i]) return 0;
    return 1;
  endfunction

  task automatic wait_lvl(input int p, input logic v, output bit ok);
    logic [3:0] l;
    ok = 0;
    for (int c = 0; c < 500 && !ok; c++) begin
      @(negedge clk);
      l = lvl();
      if (l[p] === v) ok = 1;
    end
  endtask

  task automatic run_seq(input logic [3:0] m, input logic [BW:0] nb,
                         output bit got_done);
    logic [3:0] prev, cur;
    int cd, ph, hirun, ewrun, gaprun;
    bit prev_ew, in_gap, stray_pend, stray_chk;
    obs_q.delete(); hi_q.delete(); ew_q.delete(); gap_q.delete();
    mode_mask = m; n_buses = nb; start = 1;
    @(negedge clk);
    start = 0;
    prev = 0; cd = -1; ph = 0; hirun = 0; ewrun = 0; gaprun = 0;
    prev_ew = 0; in_gap = 0; got_done = 0;
    stray_pend = stray_en; stray_chk = 0;
    for (int c = 0; c < 20000 && !got_done; c++) begin
      clr_ends();
      start = 0;
      if (stray_chk) begin
        stray_chk = 0;
        checks++;
        if (err_timeout !== 1'b1 || fail_cnt !== 3'd1 || busy !== 1'b1) begin
          errors++;
          $display("FAIL stray_start err=%b fail=%0d busy=%b want 1 1 1",
                   err_timeout, fail_cnt, busy);
        end
      end
      cur = lvl();
      for (int p = 0; p < 4; p++)
        if (cur[p] && !prev[p]) begin
          obs_q.push_back(int'(bus_sel) * 4 + p);
          ph = p;
          cd = (plan_q.size() > 0) ? plan_q.pop_front() : -1;
          hirun = 0;
        end
      if (cur != 0) hirun++;
      if (cur == 0 && prev != 0) hi_q.push_back(hirun);
      if (cd == 0) begin pulse_end(ph); cd = -1; end
      else if (cd > 0) cd--;
      if (endwait_all) ewrun++;
      if (prev_ew && !endwait_all) begin
        ew_q.push_back(ewrun); ewrun = 0; in_gap = 1; gaprun = 0;
      end
      if (in_gap) begin
        if (cur != 0) begin gap_q.push_back(gaprun); in_gap = 0; end
        else gaprun++;
      end
      if (stray_pend && err_timeout) begin
        start = 1; stray_pend = 0; stray_chk = 1;
      end
      if (done) got_done = 1;
      prev = cur;
      prev_ew = endwait_all;
      if (!got_done) @(negedge clk);
    end
    clr_ends();
    start = 0;
    checks++;
    if (!got_done) begin
      errors++;
      $display("FAIL done_timeout mask=%b n=%0d no done pulse seen", m, nb);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({osc_auto_trim, test_rx, test_tx, test_advanced, endwait_all,
         busy, done, err_timeout} !== 8'd0 || bus_sel !== '0 ||
        fail_cnt !== '0) begin
      errors++;
      $display("FAIL reset outputs not all zero bus=%0d fail=%0d busy=%b",
               bus_sel, fail_cnt, busy);
    end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_rx_tx();
    int e_obs[$] = '{1, 2, 5, 6};
    int e_ew[$] = '{EWL, EWL};
    int e_gap[$] = '{GAP, GAP};
    bit d;
    plan_q = '{2, 3, 1, 0};
    run_seq(4'b0110, 3'd2, d);
    checks++;
    if (!q_eq(obs_q, e_obs)) begin
      errors++;
      $display("FAIL rx_tx phase order got %p want %p", obs_q, e_obs);
    end
    checks++;
    if (!q_eq(ew_q, e_ew)) begin
      errors++;
      $display("FAIL rx_tx endwait width got %p want %p", ew_q, e_ew);
    end
    checks++;
    if (!q_eq(gap_q, e_gap)) begin
      errors++;
      $display("FAIL rx_tx gap got %p want %p", gap_q, e_gap);
    end
    checks++;
    if (fail_cnt !== 3'd0 || err_timeout !== 1'b0 || bus_sel !== 2'd1) begin
      errors++;
      $display("FAIL rx_tx end fail=%0d err=%b bus=%0d want 0 0 1",
               fail_cnt, err_timeout, bus_sel);
    end
  endtask

  task automatic test_timeout();
    int e_obs[$] = '{0, 4};
    int e_hi[$] = '{TO - 1, TO - 1};
    bit d;
    plan_q = '{-1, -1};
    stray_en = 1;
    run_seq(4'b0001, 3'd2, d);
    stray_en = 0;
    checks++;
    if (!q_eq(obs_q, e_obs) || !q_eq(hi_q, e_hi)) begin
      errors++;
      $display("FAIL timeout phases %p high %p want %p %p",
               obs_q, hi_q, e_obs, e_hi);
    end
    checks++;
    if (fail_cnt !== 3'd2 || err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout fail=%0d err=%b want 2 1", fail_cnt, err_timeout);
    end
  endtask

  task automatic test_coincident();
    bit d;
    plan_q = '{TO - 2};
    run_seq(4'b0001, 3'd1, d);
    checks++;
    if (fail_cnt !== 3'd0 || err_timeout !== 1'b0 || obs_q.size() != 1) begin
      errors++;
      $display("FAIL coincident fail=%0d err=%b n=%0d want 0 0 1",
               fail_cnt, err_timeout, obs_q.size());
    end
    plan_q = '{TO - 1};
    run_seq(4'b0001, 3'd1, d);
    checks++;
    if (fail_cnt !== 3'd1 || err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL late_end fail=%0d err=%b want 1 1", fail_cnt, err_timeout);
    end
  endtask

  task automatic test_abort();
    bit ok, ok2;
    mode_mask = 4'b0100; n_buses = 3'd2; start = 1;
    @(negedge clk);
    start = 0;
    wait_lvl(2, 1'b1, ok);
    tx_end = 1;
    @(negedge clk);
    tx_end = 0;
    ok2 = 0;
    for (int c = 0; c < 500 && !ok2; c++) begin
      @(negedge clk);
      if (test_tx === 1'b1 && bus_sel === 2'd1) ok2 = 1;
    end
    abort = 1;
    @(negedge clk);
    abort = 0;
    checks++;
    if (!ok || !ok2 || test_tx !== 1'b0 || busy !== 1'b0 ||
        bus_sel !== 2'd1 || endwait_all !== 1'b0) begin
      errors++;
      $display("FAIL abort reach=%b%b tx=%b busy=%b bus=%0d want 11 0 0 1",
               ok, ok2, test_tx, busy, bus_sel);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (lvl() !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle lvl=%b busy=%b want 0 0", lvl(), busy);
    end
  endtask

  task automatic test_zero();
    bit anyl;
    for (int k = 0; k < 2; k++) begin
      mode_mask = (k == 0) ? 4'b1111 : 4'b0000;
      n_buses = (k == 0) ? 3'd0 : 3'd2;
      start = 1;
      @(negedge clk);
      start = 0;
      anyl = (lvl() != 0);
      checks++;
      if (done !== 1'b1) begin
        errors++;
        $display("FAIL zero_done k=%0d done=%b want 1", k, done);
      end
      @(negedge clk);
      anyl |= (lvl() != 0);
      repeat (3) begin @(negedge clk); anyl |= (lvl() != 0); end
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || anyl) begin
        errors++;
        $display("FAIL zero_after k=%0d done=%b busy=%b lvl=%b want 0 0 0",
                 k, done, busy, anyl);
      end
    end
  endtask

  task automatic test_clamp();
    int e_obs[$] = '{0, 4, 8, 12};
    bit d;
    plan_q = '{0, 0, 0, 0, 0, 0, 0};
    run_seq(4'b0001, 3'd7, d);
    checks++;
    if (!q_eq(obs_q, e_obs) || bus_sel !== 2'd3) begin
      errors++;
      $display("FAIL clamp phases %p bus=%0d want %p 3", obs_q, bus_sel, e_obs);
    end
  endtask

  task automatic test_stray_end();
    bit ok;
    mode_mask = 4'b0011; n_buses = 3'd1; start = 1;
    @(negedge clk);
    start = 0;
    wait_lvl(0, 1'b1, ok);
    rx_end = 1; @(negedge clk);
    rx_end = 0; tx_end = 1; @(negedge clk);
    tx_end = 0; custom_end = 1; @(negedge clk);
    custom_end = 0; @(negedge clk);
    checks++;
    if (!ok || osc_auto_trim !== 1'b1 || test_rx !== 1'b0 ||
        endwait_all !== 1'b0) begin
      errors++;
      $display("FAIL stray_end reach=%b trim=%b rx=%b ew=%b want 1 1 0 0",
               ok, osc_auto_trim, test_rx, endwait_all);
    end
    trim_done = 1; @(negedge clk);
    trim_done = 0;
    wait_lvl(1, 1'b1, ok);
    checks++;
    if (!ok || osc_auto_trim !== 1'b0) begin
      errors++;
      $display("FAIL trim_to_rx reach=%b trim=%b want 1 0", ok, osc_auto_trim);
    end
    abort = 1; @(negedge clk);
    abort = 0; @(negedge clk);
  endtask

  task automatic test_waitso();
    bit d;
    sign_on = 0;
    plan_q.delete();
    run_seq(4'b0001, 3'd1, d);
    sign_on = 1;
    checks++;
    if (obs_q.size() != 0 || err_timeout !== 1'b1 || fail_cnt !== 3'd0) begin
      errors++;
      $display("FAIL waitso phases=%0d err=%b fail=%0d want 0 1 0",
               obs_q.size(), err_timeout, fail_cnt);
    end
  endtask

  task automatic test_random();
    int e_obs[$];
    int efail, nbe;
    logic [3:0] m;
    logic [BW:0] nb;
    bit d, to;
    for (int it = 0; it < 8; it++) begin
      m = 4'($urandom_range(1, 15));
      nb = 3'($urandom_range(1, 7));
      nbe = (int'(nb) > NB) ? NB : int'(nb);
      e_obs.delete(); plan_q.delete(); efail = 0;
      for (int b = 0; b < nbe; b++)
        for (int p = 0; p < 4; p++)
          if (m[p]) begin
            to = ($urandom_range(0, 3) == 0);
            e_obs.push_back(b * 4 + p);
            if (to) begin plan_q.push_back(-1); efail++; break; end
            plan_q.push_back(int'($urandom_range(0, 4)));
          end
      run_seq(m, nb, d);
      checks++;
      if (!q_eq(obs_q, e_obs)) begin
        errors++;
        $display("FAIL rand%0d phases m=%b n=%0d got %p want %p",
                 it, m, nb, obs_q, e_obs);
      end
      checks++;
      if (fail_cnt !== 3'(efail) || err_timeout !== (efail > 0) ||
          int'(bus_sel) != nbe - 1) begin
        errors++;
        $display("FAIL rand%0d end fail=%0d err=%b bus=%0d want %0d %b %0d",
                 it, fail_cnt, err_timeout, bus_sel, efail, efail > 0, nbe - 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rx_tx();
    test_timeout();
    test_coincident();
    test_abort();
    test_zero();
    test_clamp();
    test_stray_end();
    test_waitso();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
